// File: rtl/accumulator_n.sv
// Windowed sample accumulator: sums COUNT_N valid samples, pulses acc_done,
// then restarts. Saturating or wrapping arithmetic with a sticky overflow flag.
module accumulator_n #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned COUNT_N = 9,
  parameter bit          SAT_EN  = 1'b1,
  localparam int unsigned CNT_W  = (COUNT_N > 1) ? $clog2(COUNT_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_vaild,
  input  logic             acc_clear,
  input  logic [IN_W-1:0]  acc_in,
  output logic [OUT_W-1:0] acc_out,
  output logic             acc_done,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             acc_ovf
);

  localparam int unsigned     SUM_W    = OUT_W + 1;
  localparam logic [OUT_W-1:0] MAX_VAL  = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

  logic [SUM_W-1:0] sum_ext;
  logic [OUT_W-1:0] out_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;
  logic             ovf_nxt;

  // Next-state: clear beats valid; idle cycles hold everything but acc_done
  always_comb begin
    sum_ext  = {1'b0, acc_out} + SUM_W'(acc_in);
    out_nxt  = acc_out;
    cnt_nxt  = acc_cnt;
    ovf_nxt  = acc_ovf;
    done_nxt = 1'b0;
    if (acc_clear) begin
      out_nxt = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (acc_vaild) begin
      if (acc_cnt == '0) begin
        out_nxt = OUT_W'(acc_in);
        ovf_nxt = 1'b0;
      end else if (sum_ext[OUT_W]) begin
        out_nxt = SAT_EN ? MAX_VAL : sum_ext[OUT_W-1:0];
        ovf_nxt = 1'b1;
      end else begin
        out_nxt = sum_ext[OUT_W-1:0];
      end
      if (acc_cnt == LAST_CNT) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt = acc_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out  <= '0;
      acc_cnt  <= '0;
      acc_done <= 1'b0;
      acc_ovf  <= 1'b0;
    end else begin
      acc_out  <= out_nxt;
      acc_cnt  <= cnt_nxt;
      acc_done <= done_nxt;
      acc_ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_accumulator_n.sv
// Self-checking bench for accumulator_n: four configurations share one
// stimulus stream; a scoreboard queue carries per-instance expectations.
module tb_accumulator_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = '0;

  logic [11:0] o0; logic [3:0] c0; logic d0, v0;
  logic [7:0]  o1; logic [1:0] c1; logic d1, v1;
  logic [7:0]  o2; logic [1:0] c2; logic d2, v2;
  logic [11:0] o3; logic [0:0] c3; logic d3, v3;

  always #5 clk = ~clk;

  accumulator_n #(.IN_W(8), .OUT_W(12), .COUNT_N(9), .SAT_EN(1'b1)) u_def (
    .clk(clk), .rst(rst), .acc_vaild(vld), .acc_clear(clr), .acc_in(din),
    .acc_out(o0), .acc_done(d0), .acc_cnt(c0), .acc_ovf(v0));
  accumulator_n #(.IN_W(8), .OUT_W(8), .COUNT_N(3), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .acc_vaild(vld), .acc_clear(clr), .acc_in(din),
    .acc_out(o1), .acc_done(d1), .acc_cnt(c1), .acc_ovf(v1));
  accumulator_n #(.IN_W(8), .OUT_W(8), .COUNT_N(3), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .acc_vaild(vld), .acc_clear(clr), .acc_in(din),
    .acc_out(o2), .acc_done(d2), .acc_cnt(c2), .acc_ovf(v2));
  accumulator_n #(.IN_W(8), .OUT_W(12), .COUNT_N(1), .SAT_EN(1'b1)) u_one (
    .clk(clk), .rst(rst), .acc_vaild(vld), .acc_clear(clr), .acc_in(din),
    .acc_out(o3), .acc_done(d3), .acc_cnt(c3), .acc_ovf(v3));

  int outw[4] = '{12, 8, 8, 12};
  int cntn[4] = '{9, 3, 3, 1};
  int sat[4]  = '{1, 1, 0, 1};

  int m_sum[4];
  int m_cnt[4];
  int m_done[4];
  int m_ovf[4];

  typedef struct {
    int inst;
    int out;
    int cnt;
    int done;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int obs_out(input int i);
    case (i)
      0: return int'(o0);
      1: return int'(o1);
      2: return int'(o2);
      default: return int'(o3);
    endcase
  endfunction

  function automatic int obs_cnt(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  function automatic int obs_done(input int i);
    case (i)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  function automatic int obs_ovf(input int i);
    case (i)
      0: return int'(v0);
      1: return int'(v1);
      2: return int'(v2);
      default: return int'(v3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Integer reference: advance each instance by one clock edge and queue the result
  task automatic model_step(input bit v, input bit c, input int d);
    for (int i = 0; i < 4; i++) begin
      int top;
      int s;
      exp_t e;
      top = (1 << outw[i]) - 1;
      if (c) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
      end else if (v) begin
        if (m_cnt[i] == 0) begin
          m_sum[i] = d;
          m_ovf[i] = 0;
        end else begin
          s = m_sum[i] + d;
          if (s > top) begin
            m_ovf[i] = 1;
            m_sum[i] = (sat[i] != 0) ? top : s - (top + 1);
          end else begin
            m_sum[i] = s;
          end
        end
        if (m_cnt[i] == cntn[i] - 1) begin
          m_cnt[i] = 0; m_done[i] = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_done[i] = 0;
        end
      end else begin
        m_done[i] = 0;
      end
      e.inst = i; e.out = m_sum[i]; e.cnt = m_cnt[i];
      e.done = m_done[i]; e.ovf = m_ovf[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input bit c, input int d);
    @(negedge clk);
    vld = v; clr = c; din = 8'(d);
    model_step(v, c, d);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 0, 1);
        return;
      end
      e = exp_q.pop_front();
      check_eq($sformatf("d%0d_out", e.inst),  obs_out(e.inst),  e.out);
      check_eq($sformatf("d%0d_cnt", e.inst),  obs_cnt(e.inst),  e.cnt);
      check_eq($sformatf("d%0d_done", e.inst), obs_done(e.inst), e.done);
      check_eq($sformatf("d%0d_ovf", e.inst),  obs_ovf(e.inst),  e.ovf);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_d%0d_out", tag, i),  obs_out(i),  0);
      check_eq($sformatf("%s_d%0d_cnt", tag, i),  obs_cnt(i),  0);
      check_eq($sformatf("%s_d%0d_done", tag, i), obs_done(i), 0);
      check_eq($sformatf("%s_d%0d_ovf", tag, i),  obs_ovf(i),  0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Continuous stream of 5s, then a 10 that opens the next window
    for (int n = 0; n < 9; n++) step(1'b1, 1'b0, 5);
    check_eq("t1_sum45", obs_out(0), 45);
    check_eq("t1_done", obs_done(0), 1);
    check_eq("t1_cnt0", obs_cnt(0), 0);
    step(1'b1, 1'b0, 10);
    check_eq("t1_next_out", obs_out(0), 10);
    check_eq("t1_next_cnt", obs_cnt(0), 1);
    check_eq("t1_next_done", obs_done(0), 0);

    // Same stream with idle cycles interleaved
    step(1'b0, 1'b1, 0);
    for (int n = 0; n < 9; n++) begin
      step(1'b1, 1'b0, 5);
      if (n != 8) step(1'b0, 1'b0, $urandom_range(0, 255));
    end
    check_eq("t2_sum45", obs_out(0), 45);
    check_eq("t2_done", obs_done(0), 1);
    step(1'b0, 1'b0, 0);
    check_eq("t2_done_drop", obs_done(0), 0);
    check_eq("t2_hold", obs_out(0), 45);

    // Saturate vs wrap on 200,100,50
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 200);
    step(1'b1, 1'b0, 100);
    check_eq("t3_sat_2nd", obs_out(1), 255);
    check_eq("t3_sat_ovf", obs_ovf(1), 1);
    check_eq("t4_wrap_2nd", obs_out(2), 44);
    step(1'b1, 1'b0, 50);
    check_eq("t3_sat_final", obs_out(1), 255);
    check_eq("t3_sat_done", obs_done(1), 1);
    check_eq("t4_wrap_final", obs_out(2), 94);
    check_eq("t4_wrap_done", obs_done(2), 1);
    check_eq("t4_wrap_ovf", obs_ovf(2), 1);
    step(1'b1, 1'b0, 1);
    check_eq("t3_new_out", obs_out(1), 1);
    check_eq("t3_new_ovf", obs_ovf(1), 0);

    // Synchronous clear discards a coincident sample
    step(1'b0, 1'b1, 0);
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 7);
    check_eq("t5_sum28", obs_out(0), 28);
    step(1'b1, 1'b1, 9);
    check_eq("t5_clr_out", obs_out(0), 0);
    check_eq("t5_clr_cnt", obs_cnt(0), 0);

    // Asynchronous reset mid-window, between clock edges
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 7);
    @(negedge clk);
    vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 0);
    check_eq("t5_no_done", obs_done(0), 0);

    // Single-sample windows back to back
    step(1'b0, 1'b1, 0);
    for (int n = 3; n <= 5; n++) begin
      step(1'b1, 1'b0, n);
      check_eq("t6_out", obs_out(3), n);
      check_eq("t6_done", obs_done(3), 1);
      check_eq("t6_cnt", obs_cnt(3), 0);
    end

    // Random traffic with occasional clears
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 255));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
